// File: rtl/inst_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, issues reads to a 1-cycle synchronous IMEM,
// and buffers returned words with their PCs in a small FIFO for the IF/ID handshake.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        if_stall,
  output logic        imem_ce,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]     fifo_inst_q [FIFO_DEPTH];

  logic            redirect;
  logic [31:0]     target;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     credit;

  assign if_valid  = (count_q != '0);
  assign if_pc     = if_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;
  assign if_inst   = if_valid ? fifo_inst_q[rd_ptr_q] : 32'h0;
  assign imem_ce   = issue;
  assign imem_addr = pc_q;

  always_comb begin
    redirect = flush | branch_flag;
    target   = flush ? {flush_pc[31:2], 2'b00} : {branch_target[31:2], 2'b00};
    pop      = if_valid & ~if_stall & ~redirect;
    // A response returning during a redirect belongs to the old stream and is dropped.
    push     = inflight_q & ~redirect;
    credit   = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    issue    = (state_q != BOOT) & ~redirect & (credit < (CW+1)'(FIFO_DEPTH));

    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    case (state_q)
      BOOT:        state_d = FETCH;
      FETCH, HOLD: state_d = issue ? FETCH : HOLD;
      default:     state_d = FETCH;
    endcase

    if (issue) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end

    if (redirect) begin
      state_d  = FETCH;
      pc_d     = target;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer storage carries no reset; validity is tracked solely by count_q.
  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= req_pc_q;
      fifo_inst_q[wr_ptr_q] <= imem_rdata;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: a scoreboard tracks expected fetch order across redirects,
// while per-scenario tasks check cycle-exact timing of issue, output and reset.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, branch_flag, if_stall;
  logic [31:0] flush_pc, branch_target;
  logic        imem_ce, if_valid;
  logic [31:0] imem_addr, imem_rdata, if_pc, if_inst;
  logic        w_imem_ce, w_if_valid;
  logic [31:0] w_imem_addr, w_imem_rdata, w_if_pc, w_if_inst;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] sb_q [$];
  logic [31:0] exp_pc;
  logic        redir_m;
  logic [63:0] exp_m;
  logic [63:0] held;

  always #5 clk = ~clk;

  inst_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_target(branch_target), .if_stall(if_stall),
    .imem_ce(imem_ce), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_target(branch_target), .if_stall(if_stall),
    .imem_ce(w_imem_ce), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .if_valid(w_if_valid), .if_pc(w_if_pc), .if_inst(w_if_inst)
  );

  // IMEM model: word content equals word index; junk when no read was issued.
  always @(posedge clk) begin
    imem_rdata   <= imem_ce   ? (imem_addr >> 2)   : 32'hDEAD_BEEF;
    w_imem_rdata <= w_imem_ce ? (w_imem_addr >> 2) : 32'hDEAD_BEEF;
  end

  // Scoreboard monitor on the main instance.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      exp_pc = 32'h0;
    end else begin
      redir_m = flush | branch_flag;
      if (if_valid && !if_stall && !redir_m) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_pop_empty: got pc=%h inst=%h, expected no entry", if_pc, if_inst);
        end else begin
          exp_m = sb_q.pop_front();
          if ({if_pc, if_inst} !== exp_m) begin
            miscompares++;
            $display("FAIL sb_pop: got pc=%h inst=%h exp pc=%h inst=%h",
                     if_pc, if_inst, exp_m[63:32], exp_m[31:0]);
          end
        end
      end
      if (imem_ce) begin
        vectors++;
        if (redir_m || imem_addr !== exp_pc) begin
          miscompares++;
          $display("FAIL sb_issue: got addr=%h redirect=%b exp addr=%h", imem_addr, redir_m, exp_pc);
        end
        sb_q.push_back({exp_pc, exp_pc >> 2});
        exp_pc = exp_pc + 32'd4;
        vectors++;
        if (sb_q.size() > 4) begin
          miscompares++;
          $display("FAIL sb_credit: got %0d outstanding exp <= 4", sb_q.size());
        end
      end
      if (redir_m) begin
        sb_q.delete();
        exp_pc = flush ? {flush_pc[31:2], 2'b00} : {branch_target[31:2], 2'b00};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 0; branch_flag = 0; if_stall = 0;
    flush_pc = 0; branch_target = 0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({if_valid, imem_ce, imem_addr, if_pc, if_inst} !== 98'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b ce=%b addr=%h pc=%h inst=%h exp all 0",
               if_valid, imem_ce, imem_addr, if_pc, if_inst);
    end
    vectors++;
    if (w_imem_addr !== 32'hFFFF_FFF8) begin
      miscompares++;
      $display("FAIL reset_addr_w: got %h exp fffffff8", w_imem_addr);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (imem_ce !== 1'b0) begin
      miscompares++;
      $display("FAIL boot_ce: got %b exp 0", imem_ce);
    end
    step(); @(negedge clk);
    vectors++;
    if (imem_ce !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL first_issue: got ce=%b addr=%h exp ce=1 addr=0", imem_ce, imem_addr);
    end
    step(); @(negedge clk);
    vectors++;
    if (if_valid !== 1'b0 || imem_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL r2: got valid=%b addr=%h exp valid=0 addr=4", if_valid, imem_addr);
    end
    for (int k = 0; k < 8; k++) begin
      step(); @(negedge clk);
      vectors++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4*k) || if_inst !== 32'(k)) begin
        miscompares++;
        $display("FAIL seq_%0d: got valid=%b pc=%h inst=%h exp valid=1 pc=%h inst=%h",
                 k, if_valid, if_pc, if_inst, 32'(4*k), 32'(k));
      end
    end
  endtask

  task automatic test_stall();
    step();
    if_stall = 1'b1;
    @(negedge clk);
    held = {if_pc, if_inst};
    for (int k = 1; k <= 5; k++) begin
      step(); @(negedge clk);
      vectors++;
      if (if_valid !== 1'b1 || {if_pc, if_inst} !== held) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: got valid=%b pc=%h inst=%h exp valid=1 pc=%h inst=%h",
                 k, if_valid, if_pc, if_inst, held[63:32], held[31:0]);
      end
      if (k >= 3) begin
        vectors++;
        if (imem_ce !== 1'b0 || dut.state_q !== 2'd2) begin
          miscompares++;
          $display("FAIL stall_hold_ce_%0d: got ce=%b state=%0d exp ce=0 state=2",
                   k, imem_ce, dut.state_q);
        end
      end
    end
    step();
    if_stall = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vectors++;
      if (if_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_release_gap_%0d: got valid=%b exp 1", k, if_valid);
      end
      step();
    end
  endtask

  task automatic test_branch();
    do_reset();
    step(); step(); step();
    if_stall = 1'b1;
    step();
    if_stall = 1'b0;
    branch_flag = 1'b1;
    branch_target = 32'h0000_0103;
    @(negedge clk);
    vectors++;
    if (if_valid !== 1'b1 || dut.count_q !== 3'd2 || dut.inflight_q !== 1'b1) begin
      miscompares++;
      $display("FAIL branch_pre: got valid=%b count=%0d inflight=%b exp 1/2/1",
               if_valid, dut.count_q, dut.inflight_q);
    end
    step();
    branch_flag = 1'b0;
    @(negedge clk);
    vectors++;
    if (if_valid !== 1'b0 || imem_ce !== 1'b1 || imem_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL branch_issue: got valid=%b ce=%b addr=%h exp valid=0 ce=1 addr=100",
               if_valid, imem_ce, imem_addr);
    end
    step(); @(negedge clk);
    vectors++;
    if (if_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL branch_stale: got valid=%b pc=%h exp valid=0", if_valid, if_pc);
    end
    step(); @(negedge clk);
    vectors++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== 32'h40) begin
      miscompares++;
      $display("FAIL branch_first: got valid=%b pc=%h inst=%h exp 1/100/40", if_valid, if_pc, if_inst);
    end
    step(); step();
  endtask

  task automatic test_flush_priority();
    flush = 1'b1; flush_pc = 32'h380;
    branch_flag = 1'b1; branch_target = 32'h40;
    @(negedge clk);
    vectors++;
    if (if_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_pre: got valid=%b exp 1", if_valid);
    end
    step();
    flush = 1'b0; branch_flag = 1'b0;
    @(negedge clk);
    vectors++;
    if (if_valid !== 1'b0 || imem_ce !== 1'b1 || imem_addr !== 32'h380) begin
      miscompares++;
      $display("FAIL flush_issue: got valid=%b ce=%b addr=%h exp valid=0 ce=1 addr=380",
               if_valid, imem_ce, imem_addr);
    end
    step(); step(); @(negedge clk);
    vectors++;
    if (if_valid !== 1'b1 || if_pc !== 32'h380 || if_inst !== 32'hE0) begin
      miscompares++;
      $display("FAIL flush_first: got valid=%b pc=%h inst=%h exp 1/380/e0", if_valid, if_pc, if_inst);
    end
    step(); step();
  endtask

  task automatic test_boot_redirect();
    do_reset();
    branch_flag = 1'b1; branch_target = 32'h200;
    @(negedge clk);
    vectors++;
    if (imem_ce !== 1'b0) begin
      miscompares++;
      $display("FAIL boot_redir_ce: got %b exp 0", imem_ce);
    end
    step();
    branch_flag = 1'b0;
    @(negedge clk);
    vectors++;
    if (imem_ce !== 1'b1 || imem_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL boot_redir_issue: got ce=%b addr=%h exp ce=1 addr=200", imem_ce, imem_addr);
    end
    step(); step(); @(negedge clk);
    vectors++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
      miscompares++;
      $display("FAIL boot_redir_first: got valid=%b pc=%h exp 1/200", if_valid, if_pc);
    end
    step();
  endtask

  task automatic test_async_reset();
    if_stall = 1'b1;
    step(); step();
    branch_flag = 1'b1; branch_target = 32'h500;
    #1;
    vectors++;
    if (if_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL async_pre: got valid=%b exp 1", if_valid);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({if_valid, imem_ce, imem_addr, if_pc, if_inst} !== 98'h0) begin
      miscompares++;
      $display("FAIL async_clear: got v=%b ce=%b addr=%h pc=%h inst=%h exp all 0",
               if_valid, imem_ce, imem_addr, if_pc, if_inst);
    end
    step();
    branch_flag = 1'b0; if_stall = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (imem_ce !== 1'b0) begin
      miscompares++;
      $display("FAIL async_boot_ce: got %b exp 0", imem_ce);
    end
    step(); @(negedge clk);
    vectors++;
    if (imem_ce !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL async_first_issue: got ce=%b addr=%h exp ce=1 addr=0", imem_ce, imem_addr);
    end
    step(); step(); @(negedge clk);
    vectors++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL async_first_valid: got valid=%b pc=%h exp 1/0", if_valid, if_pc);
    end
    step();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
    do_reset();
    @(negedge clk);
    vectors++;
    if (w_imem_ce !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_boot_ce: got %b exp 0", w_imem_ce);
    end
    for (int k = 0; k < 3; k++) begin
      step(); @(negedge clk);
      vectors++;
      if (w_imem_ce !== 1'b1 || w_imem_addr !== exp_a[k]) begin
        miscompares++;
        $display("FAIL wrap_issue_%0d: got ce=%b addr=%h exp ce=1 addr=%h", k, w_imem_ce, w_imem_addr, exp_a[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        step(); @(negedge clk);
      end
      vectors++;
      if (w_if_valid !== 1'b1 || w_if_pc !== exp_a[k] || w_if_inst !== (exp_a[k] >> 2)) begin
        miscompares++;
        $display("FAIL wrap_out_%0d: got valid=%b pc=%h inst=%h exp 1/%h/%h",
                 k, w_if_valid, w_if_pc, w_if_inst, exp_a[k], exp_a[k] >> 2);
      end
    end
    step();
  endtask

  initial begin
    rst = 1'b1; flush = 0; branch_flag = 0; if_stall = 0;
    flush_pc = 0; branch_target = 0;
    test_reset();
    test_stall();
    test_branch();
    test_flush_priority();
    test_boot_redirect();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "timeout");
  end

endmodule
